// File: rtl/fbank_seq.sv
// Mel filter-bank sequencer: walks a 1024-entry coefficient LUT in two passes over 512
// spectrum bins, multiplies and accumulates, and emits one energy per filter end.
module fbank_seq #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned SPEC_WIDTH = 24,
    parameter int unsigned ACC_WIDTH  = 50,
    parameter int unsigned IDX_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data,
    output logic                  cfg_err,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic                  lut_wr_en,
    output logic [DATA_WIDTH-1:0] lut_wr_data,
    input  logic [DATA_WIDTH-1:0] lut_rd_data,
    output logic                  spec_rd_en,
    output logic [ADDR_WIDTH-2:0] spec_addr,
    input  logic [SPEC_WIDTH-1:0] spec_data,
    output logic                  mel_valid,
    output logic [IDX_WIDTH-1:0]  mel_idx,
    output logic [ACC_WIDTH-1:0]  mel_data
);

    localparam int unsigned ProdWidth = DATA_WIDTH - 1 + SPEC_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
    localparam logic [IDX_WIDTH-2:0]  KOne    = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_fend_q, s1_fend_d;
    logic                   s1_pass_q, s1_pass_d;
    logic                   s2_vld_q, s2_vld_d;
    logic                   s2_end_q, s2_end_d;
    logic                   s2_fend_q, s2_fend_d;
    logic                   s2_pass_q, s2_pass_d;
    logic [ProdWidth-1:0]   prod_q, prod_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [IDX_WIDTH-2:0]   k_q, k_d;
    logic                   mel_valid_q, mel_valid_d;
    logic [IDX_WIDTH-1:0]   mel_idx_q, mel_idx_d;
    logic [ACC_WIDTH-1:0]   mel_data_q, mel_data_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drain_cnt_d = drain_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_wr_en && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                addr_d = addr_q + AddrOne;
                if (&addr_q) begin
                    state_d     = StDrain;
                    drain_cnt_d = 2'd0;
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == 2'd2) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tags travel alongside the data so the accumulate stage knows where filters end.
    always_comb begin
        s1_vld_d  = (state_q == StRun);
        s1_fend_d = &addr_q[ADDR_WIDTH-2:0];
        s1_pass_d = addr_q[ADDR_WIDTH-1];
        s2_vld_d  = s1_vld_q;
        s2_end_d  = s1_vld_q && (lut_rd_data[DATA_WIDTH-1] || s1_fend_q);
        s2_fend_d = s1_vld_q && s1_fend_q;
        s2_pass_d = s1_pass_q;
        prod_d    = '0;
        if (s1_vld_q) begin
            prod_d = ProdWidth'(lut_rd_data[DATA_WIDTH-2:0]) * ProdWidth'(spec_data);
        end
    end

    always_comb begin
        acc_sum     = acc_q + ACC_WIDTH'(prod_q);
        acc_d       = acc_q;
        k_d         = k_q;
        mel_valid_d = 1'b0;
        mel_idx_d   = mel_idx_q;
        mel_data_d  = mel_data_q;
        if (s2_vld_q) begin
            if (s2_end_q) begin
                mel_valid_d = 1'b1;
                mel_data_d  = acc_sum;
                mel_idx_d   = {k_q, s2_pass_q};
                acc_d       = '0;
                // A forced end closes the pass, so the next pass restarts its filter count.
                k_d         = s2_fend_q ? '0 : k_q + KOne;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_fend_q   <= 1'b0;
            s1_pass_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_end_q    <= 1'b0;
            s2_fend_q   <= 1'b0;
            s2_pass_q   <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            mel_valid_q <= 1'b0;
            mel_idx_q   <= '0;
            mel_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            s1_vld_q    <= s1_vld_d;
            s1_fend_q   <= s1_fend_d;
            s1_pass_q   <= s1_pass_d;
            s2_vld_q    <= s2_vld_d;
            s2_end_q    <= s2_end_d;
            s2_fend_q   <= s2_fend_d;
            s2_pass_q   <= s2_pass_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            mel_valid_q <= mel_valid_d;
            mel_idx_q   <= mel_idx_d;
            mel_data_q  <= mel_data_d;
        end
    end

    // The LUT port belongs to the host while idle and to the sequencer otherwise.
    always_comb begin
        lut_addr    = (state_q == StIdle) ? cfg_addr : addr_q;
        lut_wr_en   = (state_q == StIdle) && cfg_wr_en;
        lut_wr_data = cfg_wr_data;
        spec_rd_en  = (state_q == StRun);
        spec_addr   = addr_q[ADDR_WIDTH-2:0];
        busy        = busy_q;
        done        = done_q;
        cfg_err     = cfg_err_q;
        mel_valid   = mel_valid_q;
        mel_idx     = mel_idx_q;
        mel_data    = mel_data_q;
    end

endmodule

// File: doc/fbank_seq.md
FBANK_SEQ -- requirements
Module: fbank_seq

Interface
Parameters:
REQ-001 ADDR_WIDTH, 10, coefficient LUT address width (1024 entries).
REQ-002 DATA_WIDTH, 17, LUT word width: bit16 = filter_end flag, bits15:0 = unsigned weight.
REQ-003 SPEC_WIDTH, 24, unsigned spectrum power sample width.
REQ-004 ACC_WIDTH, 50, mel accumulator and output width.
REQ-005 IDX_WIDTH, 7, mel filter index width.

Ports:
REQ-006 The reset is tb_rst, asynchronous, active-high; the clock is clk.
REQ-007 clk  in  1  rising-edge system clock.
REQ-008 tb_rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  one-cycle request to process one frame.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse at frame completion.
REQ-012 cfg_wr_en  in  1  host coefficient write strobe.
REQ-013 cfg_addr  in  ADDR_WIDTH  host write address.
REQ-014 cfg_wr_data  in  DATA_WIDTH  host write data.
REQ-015 cfg_err  out  1  one-cycle pulse when a host write is dropped.
REQ-016 lut_addr  out  ADDR_WIDTH  single-port LUT address (shared read/write).
REQ-017 lut_wr_en  out  1  LUT write enable.
REQ-018 lut_wr_data  out  DATA_WIDTH  LUT write data.
REQ-019 lut_rd_data  in  DATA_WIDTH  LUT read data, valid one cycle after lut_addr.
REQ-020 spec_rd_en  out  1  spectrum buffer read enable.
REQ-021 spec_addr  out  ADDR_WIDTH-1  spectrum bin address.
REQ-022 spec_data  in  SPEC_WIDTH  spectrum sample, valid one cycle after spec_addr.
REQ-023 mel_valid  out  1  one-cycle pulse qualifying mel_idx/mel_data.
REQ-024 mel_idx  out  IDX_WIDTH  mel filter index.
REQ-025 mel_data  out  ACC_WIDTH  mel filter energy.

Function
REQ-026 The FSM SHALL have the states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after address 1023 is issued, DRAIN->IDLE after 3 cycles with done asserted for one cycle.
REQ-027 In IDLE: lut_addr = cfg_addr, lut_wr_en = cfg_wr_en, lut_wr_data = cfg_wr_data (combinational pass-through), spec_rd_en = 0.
REQ-028 When not in IDLE: lut_wr_en = 0; a cfg_wr_en SHALL be dropped and cfg_err pulsed in the following cycle.
REQ-029 A start received while busy SHALL be ignored; cfg_wr_en and start in the same IDLE cycle: the write is performed and start is accepted.
REQ-030 In RUN: lut_addr steps 0..1023, one per cycle; spec_addr = lut_addr[8:0]; spec_rd_en = 1.
REQ-031 Pass 0 (addresses 0..511) computes even filters; pass 1 (512..1023) computes odd filters over the same bins 0..511.
REQ-032 Pipeline: data stage (t+1), registered product weight*spec_data, 40 bits (t+2), accumulate (t+3).
REQ-033 An entry SHALL end a filter when bit16 = 1 or its address is 511 or 1023 (forced end).
REQ-034 For an ending entry issued in cycle n: mel_valid = 1 in cycle n+3; mel_data = accumulator including that entry's product; the accumulator is cleared in the same cycle.
REQ-035 mel_idx = 2*k + pass, where k is the count of filters already ended in the current pass; k resets at each pass start and wraps modulo 2^(IDX_WIDTH-1).
REQ-036 Accumulation is unsigned, non-saturating; ACC_WIDTH guarantees no overflow for 512 terms.
REQ-037 Timing: start in cycle 0 -> lut_addr = 0 in cycle 1, last address in cycle 1024, final mel_valid in cycle 1027, done in cycle 1028, busy low from cycle 1028.

Reset
REQ-038 On tb_rst: state = IDLE; busy, done, cfg_err, mel_valid, spec_rd_en, lut_wr_en (registered part) = 0; mel_data, mel_idx, accumulator, counters, pipeline = 0.
REQ-039 A reset during RUN/DRAIN SHALL abort the frame immediately, with no further mel_valid or done.

Verification
REQ-040 LUT all weight = 1, no flags, spec_data = bin index -> mel (idx 0) = 130816 at cycle 515, mel (idx 1) = 130816 at cycle 1027, done at 1028.
REQ-041 Flags at addresses 9, 19, 521; weights 1; spec = 2 -> pass 0 emits idx 0,2,4 = 20,20,984; pass 1 emits idx 1,3 = 20,1004.
REQ-042 Host writes to address 5 in IDLE -> lut_wr_en = 1, lut_addr = 5; the same write during RUN -> lut_wr_en = 0, cfg_err pulse one cycle later.
REQ-043 start pulses at cycles 0 and 500 -> only one frame runs; done pulses exactly once at cycle 1028.
REQ-044 tb_rst asserted at cycle 300 of RUN -> all outputs are 0 and IDLE within one cycle; a new start then yields a complete correct frame.
REQ-045 Max weight 65535, spec 2^24-1 at all bins, no flags -> mel_data = 512*65535*(2^24-1) is exact with no wrap.
